encode_upperimm_seq: RTL
========================

// Module: encode_upperimm_seq
// PURPOSE
//  Inverse of the U-type decode path: expands a "load 32-bit constant into rd" request
//  into a legal RV32I instruction stream. Emits LUI/AUIPC + ADDI (li / la style) with the
//  ADDI sign-correction. Feeds the instruction injection port (boot ROM builder, test
//  stimulus, trap-stub generator) via a valid/ready stream, one word per beat.
// PARAMETERS
//  OPT_SKIP_ZERO_LO  1  1: omit trailing ADDI when lo12==0; 0: always emit the pair
// PORTS
//  clk        in   1   clock, rising edge
//  rst        in   1   asynchronous reset, active-high
//  req_valid  in   1   request present
//  req_ready  out  1   request accepted when req_valid && req_ready
//  req_pcrel  in   1   0: LUI-based (absolute value); 1: AUIPC-based (PC-relative offset)
//  req_rd     in   5   destination register
//  req_value  in   32  constant (pcrel=0) or offset from PC of first word (pcrel=1)
//  inst_valid out  1   inst_code valid
//  inst_ready in   1   consumer takes word when inst_valid && inst_ready
//  inst_code  out  32  encoded instruction word
//  inst_last  out  1   final word of current request
//  busy       out  1   state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE; inst_valid=0, inst_code=0, inst_last=0, busy=0; req_ready=0 while
//   rst high, else req_ready = (state==IDLE). All outputs registered except req_ready.
//  Split (captured at accept): lo12=value[11:0]; hi20=(value[31:12]+value[11]) mod 2^20.
//  Encodings: LUI={hi20,rd,7'h37}; AUIPC={hi20,rd,7'h17};
//   ADDI={lo12,rs1,3'b000,rd,7'h13}; NOP=32'h0000_0013.
//  Sequence per request:
//   rd==0           -> NOP (last).
//   pcrel=0,hi20==0 -> ADDI rd,x0,lo12 (last).
//   pcrel=0,hi20!=0 -> LUI rd,hi20; then ADDI rd,rd,lo12 (last).
//   pcrel=1         -> AUIPC rd,hi20 (AUIPC even when hi20==0); then ADDI rd,rd,lo12 (last).
//   Trailing ADDI is dropped (first word becomes last) iff OPT_SKIP_ZERO_LO && lo12==0.
//  FSM: IDLE -accept-> EMIT_HI -handshake,!last-> EMIT_LO -handshake-> IDLE;
//   EMIT_HI -handshake,last-> IDLE. No handshake: hold state.
//  Timing: accept at edge N -> first word valid after edge N (cycle N+1). Second word
//   valid cycle after first handshake. req_ready rises cycle after last handshake
//   (one bubble between requests; no same-cycle re-accept).
//  While inst_valid && !inst_ready: inst_code/inst_last held stable; inputs ignored.
//  req_* sampled only at accept; later changes have no effect.
//  hi20 wraps mod 2^20 (0xFFFFF+1 -> 0x00000), no overflow flag.
//  rst mid-sequence: immediate abort, inst_valid drops asynchronously, pending words
//   discarded, never replayed; IDLE after release.
// TESTING
//  li x5,0x12345678 -> 0x123452B7 (last=0), then 0x67828293 (last=1).
//  li x1,0xFFFFF800 -> hi20 wraps to 0: single 0x80000093, last=1.
//  li x10,0x00001800 -> 0x00002537, then 0x80050513 (lo12 negative, hi20 bumped to 2).
//  pcrel x3,0x00004000, OPT_SKIP_ZERO_LO=1 -> single 0x00004197, last=1; with =0 ->
//   0x00004197 then 0x00018193.
//  rd=0, any value -> single 0x00000013 last=1; inst_ready low 3 cycles on first word
//   of li x5 -> 0x123452B7 stable, req_ready=0, second word only after handshake.
//  Assert rst after first handshake of li x5 -> inst_valid=0 at once, 0x67828293 never
//   emitted; req_ready=1 first cycle after release.

Source files
------------

// File: rtl/encode_upperimm_seq_if.sv
// encode_upperimm_seq_if: request stream in, instruction word stream out.
interface encode_upperimm_seq_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_pcrel;
    logic [4:0]  req_rd;
    logic [31:0] req_value;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_code;
    logic        inst_last;
    modport master (
        output req_valid, req_pcrel, req_rd, req_value, inst_ready,
        input  req_ready, inst_valid, inst_code, inst_last
    );
    modport slave (
        input  req_valid, req_pcrel, req_rd, req_value, inst_ready,
        output req_ready, inst_valid, inst_code, inst_last
    );
endinterface

// File: rtl/encode_upperimm_seq.sv
// encode_upperimm_seq: expands a load-32-bit-constant request into LUI/AUIPC + ADDI words.
module encode_upperimm_seq #(
    parameter bit OPT_SKIP_ZERO_LO = 1'b1
) (
    input  logic clk,
    input  logic rst,
    encode_upperimm_seq_if.slave bus,
    output logic busy
);
    typedef enum logic [1:0] {IDLE, EMIT_HI, EMIT_LO} state_t;
    state_t      state_q, state_d;
    logic        inst_valid_q, inst_valid_d;
    logic        inst_last_q, inst_last_d;
    logic [31:0] inst_code_q, inst_code_d;
    logic [31:0] lo_code_q, lo_code_d;
    logic [19:0] hi20;
    logic [11:0] lo12;
    logic [31:0] first_word, addi_rd;
    logic        first_last, accept, handshake, no_hi;
    assign bus.req_ready  = !rst && state_q == IDLE;
    assign bus.inst_valid = inst_valid_q;
    assign bus.inst_code  = inst_code_q;
    assign bus.inst_last  = inst_last_q;
    assign busy           = state_q != IDLE;
    assign accept         = bus.req_valid && bus.req_ready;
    assign handshake      = inst_valid_q && bus.inst_ready;
    // ADDI sign-extends lo12, so a set bit 11 needs hi20 bumped by one
    always_comb begin
        lo12       = bus.req_value[11:0];
        hi20       = bus.req_value[31:12] + {19'd0, bus.req_value[11]};
        no_hi      = !bus.req_pcrel && hi20 == 20'd0;
        addi_rd    = {lo12, bus.req_rd, 3'b000, bus.req_rd, 7'h13};
        first_word = bus.req_rd == 5'd0 ? 32'h0000_0013 :
                     no_hi ? {lo12, 5'd0, 3'b000, bus.req_rd, 7'h13} :
                     {hi20, bus.req_rd, bus.req_pcrel ? 7'h17 : 7'h37};
        first_last = bus.req_rd == 5'd0 || no_hi || (OPT_SKIP_ZERO_LO && lo12 == 12'd0);
    end
    always_comb begin
        state_d      = state_q;
        inst_valid_d = inst_valid_q;
        inst_last_d  = inst_last_q;
        inst_code_d  = inst_code_q;
        lo_code_d    = lo_code_q;
        case (state_q)
            IDLE: if (accept) begin
                state_d      = EMIT_HI;
                inst_valid_d = 1'b1;
                inst_code_d  = first_word;
                inst_last_d  = first_last;
                lo_code_d    = addi_rd;
            end
            EMIT_HI: if (handshake) begin
                state_d      = inst_last_q ? IDLE : EMIT_LO;
                inst_valid_d = !inst_last_q;
                inst_code_d  = inst_last_q ? inst_code_q : lo_code_q;
                inst_last_d  = !inst_last_q;
            end
            EMIT_LO: if (handshake) begin
                state_d      = IDLE;
                inst_valid_d = 1'b0;
                inst_last_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            inst_valid_q <= 1'b0;
            inst_last_q  <= 1'b0;
            inst_code_q  <= 32'd0;
            lo_code_q    <= 32'd0;
        end else begin
            state_q      <= state_d;
            inst_valid_q <= inst_valid_d;
            inst_last_q  <= inst_last_d;
            inst_code_q  <= inst_code_d;
            lo_code_q    <= lo_code_d;
        end
    end
endmodule
